mem_arbiter: RTL and testbench

Single-port memory arbiter that sits between the instruction and data caches and the shared RAM. It produces the `ihit`/`dhit` strobes that the pipeline hazard logic consumes to enable and flush pipeline registers. It serialises instruction fetches and data loads/stores onto one RAM port, with data given priority. It also detects RAM error responses and stalled accesses.

---
 rtl/cpu_types_pkg.sv | 20 ++
 rtl/wait_counter.sv | 43 ++++
 rtl/mem_arbiter.sv | 105 ++++++++++
 tb/tb_mem_arbiter.sv | 209 ++++++++++++++++++++
 4 files changed

// File: rtl/cpu_types_pkg.sv
// Shared CPU-side types: RAM handshake status, memory arbiter states and
// the default access timeout.
package cpu_types_pkg;

  localparam int ARB_TIMEOUT_DEFAULT = 16;

  typedef enum logic [1:0] {
    FREE   = 2'b00,
    BUSY   = 2'b01,
    ACCESS = 2'b10,
    ERROR  = 2'b11
  } ramstate_t;

  typedef enum logic [1:0] {
    ARB_IDLE  = 2'b00,
    ARB_DATA  = 2'b01,
    ARB_INSTR = 2'b10
  } arb_state_t;

endpackage

// File: rtl/wait_counter.sv
// Saturating wait counter for the memory arbiter; expired_o flags the last
// cycle an access may wait for the RAM.
module wait_counter
  import cpu_types_pkg::*;
#(
  parameter int TIMEOUT = ARB_TIMEOUT_DEFAULT
) (
  input  logic CLK,
  input  logic RST,
  input  logic clr_i,
  input  logic en_i,
  output logic expired_o
);

  localparam int W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [W-1:0] LAST = W'(TIMEOUT - 1);

  logic [W-1:0] count_q, count_d;

  // NOTE: count_d takes its hold value first so no path leaves it unassigned
  // and no latch is inferred.
  always_comb begin
    count_d = count_q;
    if (clr_i) begin
      count_d = '0;
    end else if (en_i && (count_q != LAST)) begin
      count_d = count_q + W'(1);
    end
  end

  // NOTE: registers use non-blocking assignment so every flop samples the
  // pre-edge value of its neighbours.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign expired_o = (count_q == LAST);

endmodule

// File: rtl/mem_arbiter.sv
// Single-port RAM arbiter between instruction and data caches: data has
// priority, the owner is locked until hit, error, abort or timeout.
module mem_arbiter
  import cpu_types_pkg::*;
#(
  parameter int TIMEOUT = ARB_TIMEOUT_DEFAULT
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic        iREN,
  input  logic [31:0] iaddr,
  output logic [31:0] iload,
  output logic        ihit,
  input  logic        dREN,
  input  logic        dWEN,
  input  logic [31:0] daddr,
  input  logic [31:0] dstore,
  output logic [31:0] dload,
  output logic        dhit,
  output logic        ramREN,
  output logic        ramWEN,
  output logic [31:0] ramaddr,
  output logic [31:0] ramstore,
  input  logic [31:0] ramload,
  input  ramstate_t   ramstate,
  output logic        err
);

  arb_state_t state_q, state_d;
  logic       err_q, err_d;
  logic       owner_req;
  logic       expired;

  wait_counter #(.TIMEOUT(TIMEOUT)) u_wait_counter (
    .CLK       (CLK),
    .RST       (RST),
    .clr_i     (state_d == ARB_IDLE),
    .en_i      (state_q != ARB_IDLE),
    .expired_o (expired)
  );

  always_comb begin
    state_d   = state_q;
    err_d     = err_q;
    owner_req = 1'b0;
    ramREN    = 1'b0;
    ramWEN    = 1'b0;
    ramaddr   = '0;
    ramstore  = '0;
    ihit      = 1'b0;
    dhit      = 1'b0;
    iload     = '0;
    dload     = '0;

    unique case (state_q)
      ARB_IDLE: begin
        if (dREN || dWEN) begin
          state_d = ARB_DATA;
        end else if (iREN) begin
          state_d = ARB_INSTR;
        end
      end
      ARB_DATA: begin
        owner_req = dREN || dWEN;
        ramaddr   = daddr;
        ramstore  = dstore;
        ramWEN    = dWEN;
        ramREN    = dREN && !dWEN;
        dhit      = owner_req && (ramstate == ACCESS);
        if (dhit) dload = ramload;
      end
      ARB_INSTR: begin
        owner_req = iREN;
        ramaddr   = iaddr;
        ramREN    = iREN;
        ihit      = owner_req && (ramstate == ACCESS);
        if (ihit) iload = ramload;
      end
      default: state_d = ARB_IDLE;
    endcase

    // A dropped request wins over any RAM response; a late ACCESS beats timeout.
    if (state_q != ARB_IDLE) begin
      if (!owner_req || (ramstate == ACCESS)) begin
        state_d = ARB_IDLE;
      end else if ((ramstate == ERROR) || expired) begin
        err_d   = 1'b1;
        state_d = ARB_IDLE;
      end
    end
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q <= ARB_IDLE;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      err_q   <= err_d;
    end
  end

  assign err = err_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter: a transaction-level owner model checked
// every cycle, plus hand-computed expectations for each scenario.
module tb_mem_arbiter;
  import cpu_types_pkg::*;

  localparam int TB_TIMEOUT = 4;

  logic        CLK = 1'b0;
  logic        RST;
  logic        iREN, dREN, dWEN;
  logic [31:0] iaddr, daddr, dstore, ramload;
  logic [31:0] iload, dload, ramaddr, ramstore;
  logic        ihit, dhit, ramREN, ramWEN, err;
  ramstate_t   ramstate;

  int tests = 0;
  int fails = 0;

  mem_arbiter #(.TIMEOUT(TB_TIMEOUT)) dut (
    .CLK(CLK), .RST(RST),
    .iREN(iREN), .iaddr(iaddr), .iload(iload), .ihit(ihit),
    .dREN(dREN), .dWEN(dWEN), .daddr(daddr), .dstore(dstore),
    .dload(dload), .dhit(dhit),
    .ramREN(ramREN), .ramWEN(ramWEN), .ramaddr(ramaddr), .ramstore(ramstore),
    .ramload(ramload), .ramstate(ramstate), .err(err)
  );

  always #5 CLK = ~CLK;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic check1(input string name, input logic act, input logic exp);
    check(name, {31'b0, act}, {31'b0, exp});
  endtask

  // Model: who owns the RAM (0 none, 1 data, 2 instruction), how many owner
  // cycles have already gone by without a result, and the sticky error.
  int m_owner  = 0;
  int m_waited = 0;
  bit m_err    = 1'b0;

  function automatic bit owner_live();
    if (m_owner == 1) return dREN || dWEN;
    if (m_owner == 2) return iREN;
    return 1'b0;
  endfunction

  always @(posedge CLK or posedge RST) begin
    if (RST) begin
      m_owner = 0; m_waited = 0; m_err = 1'b0;
    end else if (m_owner == 0) begin
      m_owner  = (dREN || dWEN) ? 1 : (iREN ? 2 : 0);
      m_waited = 0;
    end else if (!owner_live() || ramstate == ACCESS) begin
      m_owner = 0;
    end else if (ramstate == ERROR || m_waited == TB_TIMEOUT - 1) begin
      m_err = 1'b1; m_owner = 0;
    end else begin
      m_waited++;
    end
  end

  always @(negedge CLK) begin
    bit live, e_hit;
    live  = owner_live();
    e_hit = live && (ramstate == ACCESS);
    check1("m_dhit",   dhit,   m_owner == 1 && e_hit);
    check1("m_ihit",   ihit,   m_owner == 2 && e_hit);
    check ("m_dload",  dload,  (m_owner == 1 && e_hit) ? ramload : 32'h0);
    check ("m_iload",  iload,  (m_owner == 2 && e_hit) ? ramload : 32'h0);
    check1("m_ramWEN", ramWEN, m_owner == 1 && dWEN);
    check1("m_ramREN", ramREN, (m_owner == 1 && dREN && !dWEN) || (m_owner == 2 && iREN));
    check ("m_ramaddr", ramaddr, m_owner == 1 ? daddr : (m_owner == 2 ? iaddr : 32'h0));
    check ("m_ramstore", ramstore, m_owner == 1 ? dstore : 32'h0);
    check1("m_err",    err,    m_err);
  end

  task automatic cyc();
    @(posedge CLK);
    #1;
  endtask

  initial begin
    RST = 1'b1; iREN = 0; dREN = 0; dWEN = 0;
    iaddr = 0; daddr = 0; dstore = 0; ramload = 0; ramstate = FREE;
    repeat (2) @(posedge CLK);
    #1;
    check1("rst_ramREN", ramREN, 1'b0);
    check1("rst_err", err, 1'b0);
    check ("rst_state", 32'(dut.state_q), 32'(ARB_IDLE));
    RST = 1'b0;

    // Simultaneous requests: data first, then the instruction fetch.
    cyc();
    iREN = 1; dREN = 1; daddr = 32'h40; iaddr = 32'h100;
    cyc(); ramstate = BUSY;
    @(negedge CLK);
    check1("sim_ramREN", ramREN, 1'b1);
    check ("sim_addr_d", ramaddr, 32'h40);
    cyc();
    @(negedge CLK);
    check1("sim_nohit", dhit, 1'b0);
    cyc(); ramstate = ACCESS; ramload = 32'hDEADBEEF;
    @(negedge CLK);
    check1("sim_dhit", dhit, 1'b1);
    check ("sim_dload", dload, 32'hDEADBEEF);
    check1("sim_no_ihit", ihit, 1'b0);
    cyc(); dREN = 0; ramstate = FREE;
    @(negedge CLK);
    check1("sim_idle_ren", ramREN, 1'b0);
    check ("sim_idle_state", 32'(dut.state_q), 32'(ARB_IDLE));
    cyc(); ramstate = ACCESS; ramload = 32'hCAFE0001;
    @(negedge CLK);
    check ("sim_addr_i", ramaddr, 32'h100);
    check1("sim_ihit", ihit, 1'b1);
    check ("sim_iload", iload, 32'hCAFE0001);
    cyc(); iREN = 0; ramstate = FREE;

    // Write has precedence over read.
    cyc();
    dREN = 1; dWEN = 1; dstore = 32'h12345678; daddr = 32'h80;
    cyc(); ramstate = BUSY;
    @(negedge CLK);
    check1("wr_ramWEN", ramWEN, 1'b1);
    check1("wr_ramREN", ramREN, 1'b0);
    check ("wr_ramstore", ramstore, 32'h12345678);
    check ("wr_ramaddr", ramaddr, 32'h80);
    cyc(); ramstate = ACCESS; ramload = 32'h0BAD0BAD;
    @(negedge CLK);
    check1("wr_dhit", dhit, 1'b1);
    cyc(); dREN = 0; dWEN = 0; ramstate = FREE;

    // Instruction request dropped after one BUSY cycle.
    cyc();
    iREN = 1; iaddr = 32'h400;
    cyc(); ramstate = BUSY;
    @(negedge CLK);
    check1("ab_ramREN_on", ramREN, 1'b1);
    cyc(); iREN = 0;
    @(negedge CLK);
    check1("ab_ramREN_off", ramREN, 1'b0);
    check1("ab_no_ihit", ihit, 1'b0);
    cyc(); ramstate = FREE;
    @(negedge CLK);
    check1("ab_err", err, 1'b0);

    // Timeout: BUSY for four owner cycles.
    cyc();
    dREN = 1; daddr = 32'h300;
    cyc(); ramstate = BUSY;
    cyc();
    cyc();
    cyc();
    @(negedge CLK);
    check1("to_err_pending", err, 1'b0);
    check1("to_ramREN_4th", ramREN, 1'b1);
    check1("to_no_dhit", dhit, 1'b0);
    cyc(); dREN = 0; ramstate = FREE;
    @(negedge CLK);
    check1("to_err", err, 1'b1);
    check1("to_ramREN_idle", ramREN, 1'b0);
    check ("to_state", 32'(dut.state_q), 32'(ARB_IDLE));

    // Reset in the middle of a data access.
    cyc();
    dREN = 1; daddr = 32'h500;
    cyc(); ramstate = BUSY;
    @(negedge CLK);
    check1("rs_ramREN_before", ramREN, 1'b1);
    #2 RST = 1'b1;
    #1;
    check1("rs_ramREN", ramREN, 1'b0);
    check1("rs_ramWEN", ramWEN, 1'b0);
    check1("rs_dhit", dhit, 1'b0);
    check1("rs_err", err, 1'b0);
    check ("rs_state", 32'(dut.state_q), 32'(ARB_IDLE));
    cyc(); RST = 1'b0; dREN = 0; ramstate = FREE;

    // RAM error during an instruction fetch, then a normal retry.
    cyc();
    iREN = 1; iaddr = 32'h200;
    cyc(); ramstate = ERROR;
    @(negedge CLK);
    check1("er_no_ihit", ihit, 1'b0);
    cyc(); ramstate = FREE;
    @(negedge CLK);
    check1("er_err", err, 1'b1);
    check1("er_idle_ren", ramREN, 1'b0);
    cyc(); ramstate = ACCESS; ramload = 32'h00000011;
    @(negedge CLK);
    check1("er_retry_ihit", ihit, 1'b1);
    check ("er_retry_iload", iload, 32'h00000011);
    check ("er_retry_addr", ramaddr, 32'h200);
    check1("er_err_held", err, 1'b1);
    cyc(); iREN = 0; ramstate = FREE;
    cyc();
    cyc();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
